// File: rtl/mm_pkg.sv
// Shared types and constants for the 3x3 matrix-multiply sequencer.
package mm_pkg;
  localparam int unsigned MAX_DIM = 3;
  localparam int unsigned NUM_MAC = MAX_DIM * MAX_DIM;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned DIM_W   = 2;

  typedef enum logic [3:0] {
    IDLE, CHECK, ERR, CLEAR, LOAD_W, LOAD_X, COMPUTE, DRAIN, UNLOAD, DONE
  } state_e;

  // Flat MAC / element index of grid position (r, c).
  function automatic logic [ADDR_W-1:0] mac_idx(input logic [ADDR_W-1:0] r,
                                                input logic [ADDR_W-1:0] c);
    return ADDR_W'(r * ADDR_W'(MAX_DIM) + c);
  endfunction
endpackage

// File: rtl/mm_rc_counter.sv
// Row-major 2-D counter with run-time limits; exposes its next value so the
// caller can register a decoded index in the same cycle the counter moves.
module mm_rc_counter
  import mm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] row_lim_i,
  input  logic [ADDR_W-1:0] col_lim_i,
  output logic [ADDR_W-1:0] row_nxt_o,
  output logic [ADDR_W-1:0] col_nxt_o,
  output logic              last_o
);
  logic [ADDR_W-1:0] row_q, row_d, col_q, col_d;
  logic              row_last, col_last;

  always_comb begin
    row_last = (row_q == row_lim_i - ADDR_W'(1));
    col_last = (col_q == col_lim_i - ADDR_W'(1));
    row_d    = row_q;
    col_d    = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (en_i) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ADDR_W'(1);
      end else begin
        col_d = col_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_nxt_o = row_d;
  assign col_nxt_o = col_d;
  assign last_o    = row_last && col_last;
endmodule

// File: rtl/mm_sequencer.sv
// Matrix-multiply controller: dimension check, operand load, systolic
// compute/drain and row-major result unload. All outputs are registered.
module mm_sequencer
  import mm_pkg::*;
#(
  parameter int unsigned DW        = 4,
  parameter int unsigned DRAIN_CYC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DIM_W-1:0]   row_w,
  input  logic [DIM_W-1:0]   col_w,
  input  logic [DIM_W-1:0]   row_x,
  input  logic [DIM_W-1:0]   col_x,
  input  logic               in_valid,
  input  logic [DW-1:0]      in_data,
  output logic               in_ready,
  output logic               wr_w,
  output logic               wr_x,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DW-1:0]      wr_data,
  output logic               clear_mem,
  output logic               feed_en,
  output logic [DIM_W-1:0]   feed_k,
  output logic [NUM_MAC-1:0] ld_mac,
  output logic [NUM_MAC-1:0] clear_mac,
  output logic [ADDR_W-1:0]  res_sel,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam int unsigned DCNT_W = 4;

  state_e             state_q, state_d;
  logic [DIM_W-1:0]   row_w_q, row_w_d, col_w_q, col_w_d;
  logic [DIM_W-1:0]   row_x_q, row_x_d, col_x_q, col_x_d;
  logic [ADDR_W-1:0]  nw_q, nw_d, nx_q, nx_d, wcnt_q, wcnt_d, xcnt_q, xcnt_d;
  logic [DIM_W-1:0]   kcnt_q, kcnt_d;
  logic [DCNT_W-1:0]  dcnt_q, dcnt_d;
  logic               err_q, err_d;
  logic               in_ready_q, in_ready_d, wr_w_q, wr_w_d, wr_x_q, wr_x_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d, res_sel_q, res_sel_d;
  logic [DW-1:0]      wr_data_q, wr_data_d;
  logic               clear_mem_q, clear_mem_d, feed_en_q, feed_en_d;
  logic [NUM_MAC-1:0] ld_mac_q, ld_mac_d, clear_mac_q, clear_mac_d, mask;
  logic               res_valid_q, res_valid_d, busy_q, busy_d, done_q, done_d;
  logic               in_acc, res_acc, rc_clr, rc_en, rc_last;
  logic [ADDR_W-1:0]  rc_row_nxt, rc_col_nxt;

  assign in_acc  = in_valid && in_ready_q;
  assign res_acc = res_valid_q && res_ready;

  mm_rc_counter u_rc (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (rc_clr),
    .en_i      (rc_en),
    .row_lim_i (ADDR_W'(row_w_q)),
    .col_lim_i (ADDR_W'(col_x_q)),
    .row_nxt_o (rc_row_nxt),
    .col_nxt_o (rc_col_nxt),
    .last_o    (rc_last)
  );

  // MACs that hold a real result element: r < row_w and c < col_x.
  always_comb begin
    mask = '0;
    for (int unsigned r = 0; r < MAX_DIM; r++) begin
      for (int unsigned c = 0; c < MAX_DIM; c++) begin
        mask[mac_idx(ADDR_W'(r), ADDR_W'(c))] =
          (ADDR_W'(r) < ADDR_W'(row_w_q)) && (ADDR_W'(c) < ADDR_W'(col_x_q));
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    row_w_d   = row_w_q;
    col_w_d   = col_w_q;
    row_x_d   = row_x_q;
    col_x_d   = col_x_q;
    nw_d      = nw_q;
    nx_d      = nx_q;
    wcnt_d    = wcnt_q;
    xcnt_d    = xcnt_q;
    kcnt_d    = kcnt_q;
    dcnt_d    = dcnt_q;
    err_d     = err_q;
    rc_clr    = 1'b0;
    rc_en     = 1'b0;
    wr_w_d    = 1'b0;
    wr_x_d    = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;

    case (state_q)
      IDLE: if (start) begin
        row_w_d = row_w;
        col_w_d = col_w;
        row_x_d = row_x;
        col_x_d = col_x;
        err_d   = 1'b0;
        state_d = CHECK;
      end
      CHECK: begin
        if ((row_w_q == '0) || (col_w_q == '0) || (row_x_q == '0) ||
            (col_x_q == '0) || (col_w_q != row_x_q)) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          state_d = CLEAR;
        end
      end
      ERR: state_d = IDLE;
      CLEAR: begin
        nw_d    = ADDR_W'(row_w_q) * ADDR_W'(col_w_q);
        nx_d    = ADDR_W'(row_x_q) * ADDR_W'(col_x_q);
        wcnt_d  = '0;
        xcnt_d  = '0;
        kcnt_d  = '0;
        dcnt_d  = '0;
        rc_clr  = 1'b1;
        state_d = LOAD_W;
      end
      LOAD_W: if (in_acc) begin
        wr_w_d    = 1'b1;
        wr_addr_d = wcnt_q;
        wr_data_d = in_data;
        wcnt_d    = wcnt_q + ADDR_W'(1);
        if (wcnt_q == nw_q - ADDR_W'(1)) state_d = LOAD_X;
      end
      LOAD_X: if (in_acc) begin
        wr_x_d    = 1'b1;
        wr_addr_d = xcnt_q;
        wr_data_d = in_data;
        xcnt_d    = xcnt_q + ADDR_W'(1);
        if (xcnt_q == nx_q - ADDR_W'(1)) state_d = COMPUTE;
      end
      COMPUTE: begin
        if (kcnt_q == col_w_q - DIM_W'(1)) begin
          kcnt_d  = '0;
          state_d = DRAIN;
        end else begin
          kcnt_d = kcnt_q + DIM_W'(1);
        end
      end
      DRAIN: begin
        if (dcnt_q == DCNT_W'(DRAIN_CYC - 1)) begin
          dcnt_d  = '0;
          state_d = UNLOAD;
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
      UNLOAD: if (res_acc) begin
        rc_en = 1'b1;
        if (rc_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with it.
    in_ready_d  = (state_d == LOAD_W) || (state_d == LOAD_X);
    clear_mem_d = (state_d == CLEAR);
    feed_en_d   = (state_d == COMPUTE);
    res_valid_d = (state_d == UNLOAD);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    res_sel_d   = (state_d == UNLOAD) ? mac_idx(rc_row_nxt, rc_col_nxt) : '0;
    ld_mac_d    = '0;
    clear_mac_d = '1;
    if ((state_d == COMPUTE) || (state_d == DRAIN)) begin
      ld_mac_d    = mask;
      clear_mac_d = ~mask;
    end else if ((state_d == UNLOAD) || (state_d == DONE)) begin
      clear_mac_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_w_q     <= '0;
      col_w_q     <= '0;
      row_x_q     <= '0;
      col_x_q     <= '0;
      nw_q        <= '0;
      nx_q        <= '0;
      wcnt_q      <= '0;
      xcnt_q      <= '0;
      kcnt_q      <= '0;
      dcnt_q      <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      wr_w_q      <= 1'b0;
      wr_x_q      <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      clear_mem_q <= 1'b0;
      feed_en_q   <= 1'b0;
      ld_mac_q    <= '0;
      clear_mac_q <= '1;
      res_sel_q   <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_w_q     <= row_w_d;
      col_w_q     <= col_w_d;
      row_x_q     <= row_x_d;
      col_x_q     <= col_x_d;
      nw_q        <= nw_d;
      nx_q        <= nx_d;
      wcnt_q      <= wcnt_d;
      xcnt_q      <= xcnt_d;
      kcnt_q      <= kcnt_d;
      dcnt_q      <= dcnt_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      wr_w_q      <= wr_w_d;
      wr_x_q      <= wr_x_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      clear_mem_q <= clear_mem_d;
      feed_en_q   <= feed_en_d;
      ld_mac_q    <= ld_mac_d;
      clear_mac_q <= clear_mac_d;
      res_sel_q   <= res_sel_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign wr_w      = wr_w_q;
  assign wr_x      = wr_x_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign clear_mem = clear_mem_q;
  assign feed_en   = feed_en_q;
  assign feed_k    = kcnt_q;
  assign ld_mac    = ld_mac_q;
  assign clear_mac = clear_mac_q;
  assign res_sel   = res_sel_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
endmodule

// File: tb/tb_mm_sequencer.sv
// Directed table-driven bench for mm_sequencer with a per-cycle protocol monitor.
module tb_mm_sequencer;
  logic       clk = 1'b0;
  logic       rst, start, in_valid, res_ready;
  logic [1:0] row_w, col_w, row_x, col_x, feed_k;
  logic [3:0] in_data, wr_data, wr_addr, res_sel;
  logic       in_ready, wr_w, wr_x, clear_mem, feed_en, res_valid, busy, done, err;
  logic [8:0] ld_mac, clear_mac;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         rw, cw, rx, cx;
    bit         tog, stall, err;
    int         abort;   // 0 none, 1 rst in LOAD_X, 2 rst in UNLOAD
    bit         poke;    // pulse start during COMPUTE
    logic [8:0] ld;
  } vec_t;

  vec_t vecs [10];

  mm_sequencer #(.DW(4), .DRAIN_CYC(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .row_w(row_w), .col_w(col_w), .row_x(row_x), .col_x(col_x),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_w(wr_w), .wr_x(wr_x), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_mem(clear_mem), .feed_en(feed_en), .feed_k(feed_k),
    .ld_mac(ld_mac), .clear_mac(clear_mac), .res_sel(res_sel),
    .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] beat_val(input int i);
    return 4'((i * 7 + 3) % 16);
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_wr"}, {wr_w, wr_x, clear_mem, feed_en, res_valid}, 0);
    chk({tag, "_wr_addr_data"}, {wr_addr, wr_data}, 0);
    chk({tag, "_feed_k"}, feed_k, 0);
    chk({tag, "_ld_mac"}, ld_mac, 0);
    chk({tag, "_clear_mac"}, clear_mac, 9'h1FF);
    chk({tag, "_res_sel"}, res_sel, 0);
  endtask

  // Runs one operation from a negedge in IDLE; returns at a negedge in IDLE.
  task automatic run_op(input vec_t v);
    int nw, nx, sent, w_seen, x_seen, k_seen, r_seen, dones, clrs, c0, stall_left;
    bit fin, poked, got_res;
    logic [3:0] exp_sel [$];
    logic [8:0] nld;
    nw = v.rw * v.cw; nx = v.rx * v.cx; nld = ~v.ld;
    sent = 0; w_seen = 0; x_seen = 0; k_seen = 0; r_seen = 0;
    dones = 0; clrs = 0; c0 = -1; stall_left = 3;
    fin = 0; poked = 0; got_res = 0;
    exp_sel = {};
    for (int r = 0; r < v.rw; r++)
      for (int c = 0; c < v.cx; c++) exp_sel.push_back(4'(r * 3 + c));

    start = 1'b1;
    row_w = 2'(v.rw); col_w = 2'(v.cw); row_x = 2'(v.rx); col_x = 2'(v.cx);
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!busy) begin fin = 1; break; end
      if (wr_w) begin
        chk("wr_w_addr", wr_addr, w_seen);
        chk("wr_w_data", wr_data, beat_val(w_seen));
        w_seen++;
      end
      if (wr_x) begin
        chk("wr_x_addr", wr_addr, x_seen);
        chk("wr_x_data", wr_data, beat_val(nw + x_seen));
        x_seen++;
      end
      if (clear_mem) clrs++;
      if (feed_en) begin
        if (c0 < 0) c0 = cyc;
        chk("feed_k", feed_k, k_seen);
        chk("ld_mac_compute", ld_mac, v.ld);
        chk("clear_mac_compute", clear_mac, nld);
        k_seen++;
      end
      if (res_valid) begin
        if (!got_res) begin
          chk("latency", cyc - c0, v.cw + 2);
          got_res = 1;
        end
        chk("res_sel", res_sel, (r_seen < exp_sel.size()) ? exp_sel[r_seen] : 15);
        chk("mac_hold_unload", {ld_mac, clear_mac}, 0);
      end
      if (done) dones++;
      if ((v.abort == 1 && x_seen == 1) || (v.abort == 2 && res_valid)) begin
        rst = 1'b1; in_valid = 1'b1; in_data = 4'hF; res_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        check_reset("abort");
        return;
      end
      in_valid = (sent < nw + nx) && !v.err && (!v.tog || (cyc % 2 == 0));
      in_data  = beat_val(sent);
      if (in_valid && in_ready) sent++;
      res_ready = 1'b1;
      if (v.stall && r_seen == 4 && stall_left > 0) begin
        res_ready = 1'b0;
        stall_left--;
      end
      if (res_valid && res_ready) r_seen++;
      start = 1'b0;
      if (v.poke && k_seen == 1 && !poked) begin
        start = 1'b1; row_w = 2'd1; col_w = 2'd1; row_x = 2'd1; col_x = 2'd1;
        poked = 1;
      end
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    chk("op_finished", fin, 1);
    chk("w_writes", w_seen, v.err ? 0 : nw);
    chk("x_writes", x_seen, v.err ? 0 : nx);
    chk("feed_steps", k_seen, v.err ? 0 : v.cw);
    chk("results", r_seen, v.err ? 0 : exp_sel.size());
    chk("done_pulses", dones, v.err ? 0 : 1);
    chk("clear_mem_pulses", clrs, v.err ? 0 : 1);
    chk("err_end", err, v.err);
    chk("in_ready_idle", in_ready, 0);
    if (v.err) begin
      repeat (3) @(negedge clk);
      chk("err_sticky", err, 1);
      chk("err_idle_busy", busy, 0);
    end
  endtask

  initial begin
    vecs[0] = '{rw:2, cw:3, rx:3, cx:2, tog:0, stall:0, err:0, abort:0, poke:0, ld:9'h01B};
    vecs[1] = '{rw:2, cw:2, rx:3, cx:2, tog:0, stall:0, err:1, abort:0, poke:0, ld:9'h000};
    vecs[2] = '{rw:3, cw:3, rx:3, cx:3, tog:1, stall:1, err:0, abort:0, poke:0, ld:9'h1FF};
    vecs[3] = '{rw:1, cw:1, rx:1, cx:1, tog:0, stall:0, err:0, abort:0, poke:0, ld:9'h001};
    vecs[4] = '{rw:2, cw:2, rx:2, cx:2, tog:0, stall:0, err:0, abort:1, poke:0, ld:9'h01B};
    vecs[5] = '{rw:2, cw:2, rx:2, cx:2, tog:0, stall:0, err:0, abort:2, poke:0, ld:9'h01B};
    vecs[6] = '{rw:2, cw:2, rx:2, cx:2, tog:0, stall:0, err:0, abort:0, poke:0, ld:9'h01B};
    vecs[7] = '{rw:2, cw:3, rx:3, cx:2, tog:0, stall:0, err:0, abort:0, poke:1, ld:9'h01B};
    vecs[8] = '{rw:0, cw:2, rx:2, cx:1, tog:0, stall:0, err:1, abort:0, poke:0, ld:9'h000};
    vecs[9] = '{rw:3, cw:1, rx:1, cx:3, tog:0, stall:0, err:0, abort:0, poke:0, ld:9'h1FF};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    row_w = '0; col_w = '0; row_x = '0; col_x = '0;
    repeat (2) @(negedge clk);
    check_reset("reset");

    // start while reset is held must not launch an operation
    start = 1'b1; row_w = 2'd1; col_w = 2'd1; row_x = 2'd1; col_x = 2'd1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("start_in_reset_busy", busy, 0);

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mm_sequencer.md
Name: mm_sequencer

Overview:
- Top-level controller for the 3x3 matrix-multiply accelerator.
- Latches the W/X dimensions, checks them, and streams operands into the memory banks with a valid/ready handshake.
- Clears, enables and drains the 9-MAC systolic array, then unloads results one per handshake in row-major order.
- Sits between the host/testbench stream interface and the memory-bank + MAC-array datapath.

Parameters:
- MAX_DIM, 3, maximum rows/cols per matrix; fixes the 3x3 MAC grid.
- DRAIN_CYC, 2, pipeline-flush cycles after the last feed step (systolic skew = MAX_DIM-1).
- DW, 4, operand data width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin an operation; sampled only in IDLE
- row_w, col_w, row_x, col_x  in  2 each  matrix dimensions; latched on accepted start
- in_valid  in  1  operand beat valid
- in_data  in  DW  operand beat, row-major, all of W then all of X
- in_ready  out  1  controller accepts a beat this cycle
- wr_w, wr_x  out  1 each  write strobe to W / X bank
- wr_addr  out  4  element address 0..8
- wr_data  out  DW  in_data registered alongside the strobes
- clear_mem  out  1  clear both operand banks
- feed_en  out  1  datapath presents operand step feed_k to the array edge
- feed_k  out  2  inner-dimension step index 0..col_w-1
- ld_mac  out  9  per-MAC accumulate enable, index r*3+c
- clear_mac  out  9  per-MAC clear
- res_sel  out  4  MAC index whose result is presented
- res_valid  out  1  result beat valid
- res_ready  in  1  consumer accepts a result beat
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at completion
- err  out  1  sticky dimension error; cleared by the next accepted start or by rst

Behaviour:
- Reset: state IDLE; every output 0 except clear_mac=9'h1FF; counters and latched dims 0.
- IDLE -> CHECK on start. Dims are latched in the same cycle. A start outside IDLE is ignored.
- CHECK (1 cycle) -> ERR if any dim==0 or col_w!=row_x; otherwise -> CLEAR.
- ERR (1 cycle): err set, then -> IDLE.
- CLEAR (1 cycle): clear_mem=1, clear_mac=9'h1FF. Loads nW=row_w*col_w and nX=row_x*col_x (4-bit, max 9). -> LOAD_W.
- LOAD_W: in_ready=1. On in_valid&&in_ready, the next cycle shows wr_w=1, wr_addr=wcnt, wr_data=in_data, and wcnt increments. When beat nW-1 is accepted -> LOAD_X.
- LOAD_X: same as LOAD_W using wr_x / xcnt / nX. After beat nX-1 -> COMPUTE.
- in_ready is 0 in every state other than LOAD_W and LOAD_X. No beat is lost across the W->X boundary.
- COMPUTE: feed_en=1, feed_k counts 0..col_w-1, one step per cycle, no stalls.
- In COMPUTE and DRAIN: ld_mac[r*3+c]=1 iff r<row_w && c<col_x. clear_mac=~ld_mac, so unused MACs stay cleared.
- After step col_w-1 -> DRAIN for exactly DRAIN_CYC cycles: feed_en=0, ld_mac held. -> UNLOAD.
- UNLOAD: ld_mac=0, clear_mac=0, so results are held. res_valid=1 and res_sel=r*3+c, walking only valid (r<row_w, c<col_x) entries row-major. Advances only on res_valid&&res_ready. res_sel is stable while stalled.
- After the last beat (r=row_w-1, c=col_x-1) -> DONE.
- DONE (1 cycle): done=1, then -> IDLE.
- Total compute latency: col_w + DRAIN_CYC cycles from the first COMPUTE cycle to the first res_valid.
- rst mid-operation: abort immediately to reset values. No partial writes follow the reset cycle.
- Counter widths are 4-bit. Dims are zero-extended before compares. 3*3=9 must not overflow.

Decomposition:
- Package mm_pkg holds:
  - state enum: IDLE, CHECK, ERR, CLEAR, LOAD_W, LOAD_X, COMPUTE, DRAIN, UNLOAD, DONE
  - constants: MAX_DIM=3, NUM_MAC=9, ADDR_W=4
  - function mac_idx(r,c)=r*3+c
- One sub-module, mm_rc_counter: 2-D row/col counter with run-time limits, enable, clear and last flag. Used for UNLOAD; optionally reused for the load address.

Test Plan:
- 2x3 * 3x2: start, 6 W beats then 6 X beats, in_valid continuous -> wr_w addr 0..5, wr_x addr 0..5; feed_k 0,1,2; ld_mac=9'b000011011; first res_valid 5 cycles after COMPUTE entry; res_sel 0,1,3,4; done pulse.
- Dimension mismatch (col_w=2, row_x=3) -> ERR; err=1 stays high in IDLE, no wr_* or clear_mem; next valid start clears err.
- 3x3 * 3x3 with in_valid toggling every other cycle and res_ready low for 3 cycles mid-unload -> all 18 beats written exactly once; res_sel holds during the stall; 9 results delivered 0..8.
- 1x1 * 1x1 -> nW=nX=1; one feed step; ld_mac=9'b000000001; single result res_sel=0; done pulse.
- rst asserted during LOAD_X and again during UNLOAD -> next cycle IDLE, all outputs at reset values, clear_mac=9'h1FF; a subsequent 2x2 operation completes correctly.
- start pulsed while busy (in COMPUTE) -> ignored; the current operation's outputs are unchanged.
